// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity modes and the
// baud divider calculation used by the RX and TX blocks.
package uart_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Clocks per oversampling sub-tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq,
                                    input int baud,
                                    input int os);
        longint num;
        longint den;
        den = longint'(baud) * longint'(os);
        num = longint'(clk_freq) + den / 2;
        return int'(num / den);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running sub-tick divider: one-cycle tick every DIV clocks.
// clear_i restarts the count so the phase follows an external event.
module uart_baud_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    // Next count: wrap on tick, restart on clear.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) cnt_d = '0;
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority voting,
// optional parity, 1/2 stop bits and a valid/ready output register.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2;
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [SW-1:0] SUB_M1  = SW'(MID - 1);
    localparam logic [SW-1:0] SUB_M   = SW'(MID);
    localparam logic [SW-1:0] SUB_P1  = SW'(MID + 1);
    localparam logic [SW-1:0] SUB_END = SW'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 ||
            OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
            STOP_BITS < 1 || STOP_BITS > 2 ||
            PARITY_MODE < 0 || PARITY_MODE > 2 ||
            DIV < 1) begin : g_bad_param
            $error("uart_rx_os: illegal parameter set");
        end
    endgenerate

    logic [1:0]           sync_q;
    logic                 rxs;
    logic                 rxs_prev_q;
    logic [2:0]           state_q, state_d;
    logic [SW-1:0]        sub_q, sub_d;
    logic [3:0]           bit_q, bit_d;
    logic                 s0_q, s0_d;
    logic                 s1_q, s1_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;
    logic                 tick;
    logic                 start_edge;
    logic                 maj;
    logic                 at_mid;
    logic                 at_end;
    logic                 done;
    logic                 done_fe;

    assign rxs        = sync_q[1];
    assign start_edge = (state_q == ST_IDLE) && rxs_prev_q && !rxs;
    assign maj        = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
    assign at_mid     = tick && (sub_q == SUB_P1);
    assign at_end     = tick && (sub_q == SUB_END);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear_i (start_edge),
        .tick_o  (tick)
    );

    // Receive FSM, sub-tick sampling and frame status.
    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        bit_d   = bit_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        done    = 1'b0;
        done_fe = ferr_q;
        if (tick && state_q != ST_IDLE) begin
            sub_d = (sub_q == SUB_END) ? '0 : sub_q + 1'b1;
            if (sub_q == SUB_M1) s0_d = rxs;
            if (sub_q == SUB_M)  s1_d = rxs;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_START;
                    sub_d   = '0;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (at_mid && maj) begin
                    state_d = ST_IDLE;
                end else if (at_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (at_mid) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                if (at_end) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ?
                                  ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (at_mid) begin
                    if (PARITY_MODE == PARITY_ODD)
                        perr_d = ~(^shreg_q ^ maj);
                    else
                        perr_d = ^shreg_q ^ maj;
                end
                if (at_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (at_mid) begin
                    if (!maj) ferr_d = 1'b1;
                    if (bit_q == LAST_STOP) begin
                        done    = 1'b1;
                        done_fe = ferr_q | ~maj;
                        sub_d   = '0;
                        bit_d   = '0;
                        state_d = maj ? ST_IDLE : ST_WAIT_IDLE;
                    end
                end else if (at_end) begin
                    bit_d = bit_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register: load on completion, drop and flag on overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        ovr_d   = 1'b0;
        if (done) begin
            if (!valid_q || rx_ready) begin
                data_d  = shreg_q;
                pe_d    = perr_q;
                fe_d    = done_fe;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers; synchroniser idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            sub_q      <= '0;
            bit_q      <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx};
            rxs_prev_q <= rxs;
            state_q    <= state_d;
            sub_q      <= sub_d;
            bit_q      <= bit_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: three instances (8E1, 8O1, 9N2)
// driven with directed frames; a monitor pops expected frames.
module tb_uart_rx_os;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;
    logic [7:0] da, db;
    logic [8:0] dc;
    logic va, vb, vc, pa, pb, pc, fa, fb, fc;
    logic oa, ob, oc, ba, bb, bc;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int n_chk = 0;
    int n_fail = 0;
    int ovc[3] = '{0, 0, 0};
    bit pv[3] = '{0, 0, 0};
    bit pr[3] = '{0, 0, 0};
    bit po[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    uart_rx_os #(.CLK_FREQ(614_400), .BAUD(9600), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_ready(rdy_a),
        .rx_data(da), .rx_valid(va), .parity_err(pa),
        .frame_err(fa), .overrun(oa), .busy(ba));

    uart_rx_os #(.CLK_FREQ(614_400), .BAUD(9600), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_ready(rdy_b),
        .rx_data(db), .rx_valid(vb), .parity_err(pb),
        .frame_err(fb), .overrun(ob), .busy(bb));

    uart_rx_os #(.CLK_FREQ(614_400), .BAUD(9600), .OVERSAMPLE(16),
                 .DATA_BITS(9), .PARITY_MODE(0), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst(rst), .rx(rx_c), .rx_ready(rdy_c),
        .rx_data(dc), .rx_valid(vc), .parity_err(pc),
        .frame_err(fc), .overrun(oc), .busy(bc));

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic mon(input int i, input logic v, input logic r,
                       input logic [8:0] d, input logic p,
                       input logic f, input logic o);
        exp_t e;
        bit have;
        have = 0;
        if (v && (!pv[i] || pr[i])) begin
            case (i)
                0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1; end
                1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1; end
                default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1; end
            endcase
            if (!have) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_frame dut%0d: got %0h expected none",
                         i, d);
            end else begin
                chk($sformatf("data%0d", i), d, e.d);
                chk($sformatf("perr%0d", i), p, e.pe);
                chk($sformatf("ferr%0d", i), f, e.fe);
            end
        end
        if (o) begin
            ovc[i]++;
            chk($sformatf("ovr_width%0d", i), po[i], 0);
        end
        pv[i] = v;
        pr[i] = r;
        po[i] = o;
    endtask

    always @(negedge clk) begin
        mon(0, va, rdy_a, {1'b0, da}, pa, fa, oa);
        mon(1, vb, rdy_b, {1'b0, db}, pb, fb, ob);
        mon(2, vc, rdy_c, dc, pc, fc, oc);
    end

    task automatic setrx(input int d, input logic v);
        case (d)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame, 64 clocks per bit, starting now (posedge + 1).
    task automatic send(input int d, input logic [8:0] data,
                        input int nb, input bit hp, input bit par,
                        input int ns, input bit st0, input bit st1,
                        input int gbit, input int cut);
        logic bits [0:12];
        int n;
        bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) bits[1+i] = data[i];
        n = 1 + nb;
        if (hp) begin bits[n] = par; n++; end
        bits[n] = st0;
        n++;
        if (ns == 2) begin bits[n] = st1; n++; end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < 64; c++) begin
                if (b * 64 + c >= cut) return;
                setrx(d, bits[b] ^ (b == gbit && c >= 35 && c <= 38));
                @(posedge clk);
                #1;
            end
        end
    endtask

    function automatic exp_t mk(input logic [8:0] d, input logic pe,
                                input logic fe);
        exp_t e;
        e.d = d;
        e.pe = pe;
        e.fe = fe;
        return e;
    endfunction

    localparam int FULL = 100000;

    initial begin
        #2;
        chk("rst_valid", va, 0);
        chk("rst_data", da, 0);
        chk("rst_perr", pa, 0);
        chk("rst_ferr", fa, 0);
        chk("rst_ovr", oa, 0);
        chk("rst_busy", ba, 0);
        chk("rst_data_c", dc, 0);
        chk("rst_busy_c", bc, 0);
        idle(3);
        rst = 1'b0;
        idle(10);

        qa.push_back(mk(9'h55, 0, 0));
        send(0, 9'h55, 8, 1, 0, 1, 1, 1, -1, FULL);
        idle(20);

        qa.push_back(mk(9'hA3, 1, 0));
        qb.push_back(mk(9'hA3, 0, 0));
        fork
            send(0, 9'hA3, 8, 1, 1, 1, 1, 1, -1, FULL);
            send(1, 9'hA3, 8, 1, 1, 1, 1, 1, -1, FULL);
        join
        idle(20);

        qa.push_back(mk(9'h7E, 0, 1));
        send(0, 9'h7E, 8, 1, 0, 1, 0, 1, -1, FULL);
        for (int k = 0; k < 3; k++) begin
            idle(64);
            chk("busy_line_low", ba, 1);
        end
        rx_a = 1'b1;
        idle(10);
        chk("busy_after_high", ba, 0);
        idle(20);

        rx_a = 1'b0;
        idle(2);
        rx_a = 1'b1;
        idle(100);
        chk("busy_after_glitch", ba, 0);

        qa.push_back(mk(9'h3C, 0, 0));
        send(0, 9'h3C, 8, 1, 0, 1, 1, 1, 4, FULL);
        idle(20);

        rdy_a = 1'b0;
        qa.push_back(mk(9'h11, 0, 0));
        send(0, 9'h11, 8, 1, 0, 1, 1, 1, -1, FULL);
        idle(20);
        send(0, 9'h22, 8, 1, 0, 1, 1, 1, -1, FULL);
        idle(20);
        chk("held_data", da, 8'h11);
        qa.push_back(mk(9'h33, 0, 0));
        fork
            send(0, 9'h33, 8, 1, 0, 1, 1, 1, -1, FULL);
            begin
                repeat (682) @(posedge clk);
                #1;
                rdy_a = 1'b1;
            end
        join
        idle(20);

        rdy_a = 1'b0;
        qa.push_back(mk(9'h0F, 0, 0));
        send(0, 9'h0F, 8, 1, 0, 1, 1, 1, -1, FULL);
        idle(20);
        send(0, 9'h5A, 8, 1, 0, 1, 1, 1, -1, 64 * 5 + 30);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", va, 0);
        chk("mid_rst_data", da, 0);
        chk("mid_rst_perr", pa, 0);
        chk("mid_rst_ferr", fa, 0);
        chk("mid_rst_busy", ba, 0);
        rx_a = 1'b1;
        idle(3);
        rst = 1'b0;
        rdy_a = 1'b1;
        idle(20);
        qa.push_back(mk(9'h5A, 0, 0));
        send(0, 9'h5A, 8, 1, 0, 1, 1, 1, -1, FULL);
        idle(20);

        qc.push_back(mk(9'h1C5, 0, 0));
        send(2, 9'h1C5, 9, 0, 0, 2, 1, 1, -1, FULL);
        idle(20);
        qc.push_back(mk(9'h1C5, 0, 1));
        send(2, 9'h1C5, 9, 0, 0, 2, 1, 0, -1, FULL);
        rx_c = 1'b1;
        idle(200);

        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        chk("qc_empty", qc.size(), 0);
        chk("ovr_count_a", ovc[0], 1);
        chk("ovr_count_b", ovc[1], 0);
        chk("ovr_count_c", ovc[2], 0);
        chk("final_busy_c", bc, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver: next-generation serial RX for the peripheral set.
- Synchronises `rx` and detects/validates the start bit with 3-sample majority voting.
- Receives 5–9 data bits LSB-first, checks optional parity and 1 or 2 stop bits.
- Presents each frame on a valid/ready output register with parity, framing and overrun status.
- Feeds the bus-side UART wrapper and FIFO in place of fixed 8-bit, single-sample receive logic.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- OVERSAMPLE, 16: sub-ticks per bit; even, ≥8.
- DATA_BITS, 8: data bits per frame; legal 5..9.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: legal 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- rx_ready  in  1  consumer accepts rx_data this cycle.
- rx_data  out  DATA_BITS  received word, bit 0 = first bit received.
- rx_valid  out  1  rx_data and status flags hold an unread frame.
- parity_err  out  1  parity mismatch for the held frame (0 when PARITY_MODE = 0).
- frame_err  out  1  a stop bit sampled 0 in the held frame.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst = 1):
  - All outputs 0. rx_data = 0.
  - Synchroniser flops = 1. FSM = IDLE. Tick and bit counters = 0.
- Synchroniser: 2 flops. All logic uses the synchronised `rxs`, giving 2 cycles of input latency.
- Tick generator:
  - DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), rounded to nearest.
  - 1-cycle `tick` every DIV clocks.
  - Divider cleared on IDLE→START so the phase aligns to the start edge.
- Sub-tick counter: 0..OVERSAMPLE-1 per bit. Let MID = OVERSAMPLE/2.
  - Samples taken at sub-ticks MID-1, MID, MID+1.
  - Bit value = majority of the 3 samples, decided at MID+1.
  - Bit ends at sub-tick OVERSAMPLE-1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: on `rxs` 1→0 go to START.
  - START: majority = 1 → IDLE (false start, no flags). Majority = 0 → DATA at bit end, bit counter = 0.
  - DATA: shift the majority bit into the shift register LSB-first. After bit DATA_BITS-1 go to PARITY if PARITY_MODE ≠ 0, else STOP.
  - PARITY: error when (XOR of data ^ parity bit) ≠ 0 for even mode, or = 0 for odd mode. Result latched internally.
  - STOP:
    - Majority of each stop bit is checked; any 0 sets the internal frame error.
    - For STOP_BITS = 2, a second stop period follows the first.
    - Frame completes at MID+1 of the final stop bit; remaining sub-ticks are not waited.
    - Next state is IDLE if the final stop sample = 1, else WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs` = 1, then IDLE. This covers break and line-low conditions and prevents a false restart.
- Output register, on frame completion (cycle C):
  - If rx_valid = 0, or rx_ready = 1 in cycle C: load rx_data, parity_err, frame_err; rx_valid = 1 from cycle C+1.
  - If rx_valid = 1 and rx_ready = 0: new frame discarded, held data unchanged, overrun = 1 for exactly cycle C+1.
- Handshake:
  - rx_valid && rx_ready with no completion: rx_valid → 0 next cycle; rx_data and flags hold their last values.
  - rx_ready while rx_valid = 0: ignored.
- Latency: rx_valid rises 1 clock after the final stop mid-sample, about (1 + DATA_BITS + P + STOP_BITS - 0.5 + 3/OVERSAMPLE) bit times after the start edge (P = 1 if parity enabled, else 0).
- Reset mid-frame: immediate abort to IDLE with all outputs cleared; a partial frame is never presented.
- Illegal parameters: elaboration error via a generate-time check (DATA_BITS out of 5..9, odd OVERSAMPLE, STOP_BITS ∉ {1,2}, PARITY_MODE > 2, DIV < 1).

Decomposition:
- Package `uart_pkg`:
  - FSM state enum.
  - PARITY_NONE/EVEN/ODD constants.
  - DIV calculation function, shared with the future uart_tx_os.
- Sub-module `uart_baud_tick`: counter with a clear input, parameter DIV, output `tick`. Reused by TX.

Test Plan:
- Simulation setting: CLK_FREQ = 614_400, BAUD = 9600, OVERSAMPLE = 16 (DIV = 4), unless stated otherwise.
- 0x55, PARITY_MODE = 1, parity bit 0, 1 stop; rx_ready held 1 → rx_data = 0x55, parity_err = 0, frame_err = 0, rx_valid high for 1 cycle.
- 0xA3 with parity bit 1 in even mode → rx_data = 0xA3, parity_err = 1. Same frame with PARITY_MODE = 2 → parity_err = 0.
- 0x7E with stop bit forced 0, line then low for 3 bit times → frame_err = 1, busy stays high until rx returns high, no second frame.
- 2-clock low glitch on idle line → no rx_valid, no flags. Glitch of 1 sub-tick inside a data bit → bit still decoded correctly by majority.
- Frames 0x11 then 0x22 with rx_ready = 0 → rx_data stays 0x11, overrun pulses 1 cycle. Then ready = 1 coinciding with a third frame 0x33 completing → 0x33 loaded, no overrun.
- rst asserted during data bit 4 of 0x5A → all outputs 0 immediately. Next clean frame 0x5A received correctly.
- DATA_BITS = 9, STOP_BITS = 2: 0x1C5 → rx_data = 0x1C5. Second stop bit forced 0 → frame_err = 1.
